// File: rtl/shift_wb_buffer.sv
// Writeback buffer that sits after the immediate shifter. It holds shift results together
// with their destination index and zero/negative/carry flags, and uses valid/ready on both sides.
module shift_wb_buffer #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ADDR_W-1:0]         in_dest,
    input  logic [WIDTH-1:0]          in_operand,
    input  logic [WIDTH-1:0]          in_result,
    input  logic [4:0]                in_immediate,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ADDR_W-1:0]         out_dest,
    output logic [WIDTH-1:0]          out_result,
    output logic                      out_zero,
    output logic                      out_negative,
    output logic                      out_carry,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [ADDR_W-1:0] mem_dest   [DEPTH];
    logic [WIDTH-1:0]  mem_result [DEPTH];
    logic [2:0]        mem_flags  [DEPTH];

    logic push;
    logic pop;
    logic carry_in;
    int   imm_k;

    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign imm_k = int'($signed(in_immediate));

    // Carry is the last bit to leave the operand: bit WIDTH-k on a left shift, bit m-1 on a right shift by m.
    always_comb begin
        carry_in = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if ((imm_k > 0) && (i == WIDTH - imm_k))
                carry_in = in_operand[i];
            if ((imm_k < 0) && (i == -imm_k - 1))
                carry_in = in_operand[i];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_dest[wr_ptr]   <= in_dest;
            mem_result[wr_ptr] <= in_result;
            mem_flags[wr_ptr]  <= {(in_result == '0), in_result[WIDTH-1], carry_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Gate the head with out_valid so an empty buffer presents zeros instead of stale storage.
    assign out_dest     = out_valid ? mem_dest[rd_ptr]   : '0;
    assign out_result   = out_valid ? mem_result[rd_ptr] : '0;
    assign out_zero     = out_valid & mem_flags[rd_ptr][2];
    assign out_negative = out_valid & mem_flags[rd_ptr][1];
    assign out_carry    = out_valid & mem_flags[rd_ptr][0];

endmodule

// File: doc/shift_wb_buffer.md
Name: shift_wb_buffer

Overview:
- Downstream stage of the 16-bit immediate shifter (signed 5-bit immediate: negative = logical right, non-negative = left).
- Captures each shift result with its destination register index and pre-shift operand, and derives zero/negative/carry flags.
- Buffers entries in a small FIFO with valid/ready on both sides, so register-file writeback can stall without losing results.

Parameters:
WIDTH, 16, data width of operand and result
ADDR_W, 3, register-file destination index width
DEPTH, 2, FIFO entries; power of two, >= 2

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream entry present
in_ready  output  1  buffer can accept this cycle
in_dest  input  ADDR_W  destination register index
in_operand  input  WIDTH  pre-shift operand (shifter in0)
in_result  input  WIDTH  shifter output
in_immediate  input  5  signed shift amount given to shifter
out_valid  output  1  head entry valid
out_ready  input  1  writeback consumes head
out_dest  output  ADDR_W  head destination index
out_result  output  WIDTH  head result
out_zero  output  1  head result == 0
out_negative  output  1  head result[WIDTH-1]
out_carry  output  1  last bit shifted out (see rules)
count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst_n low, asynchronous): read/write pointers = 0, count = 0, out_valid = 0, in_ready = 1. out_dest, out_result and all flags read 0. Storage contents need not be cleared.
- Reset asserted mid-operation discards all entries immediately; nothing is replayed after release.
- Push: in_valid & in_ready at a rising edge writes {dest, result, zero, negative, carry} at the write pointer and increments it.
- Pop: out_valid & out_ready at a rising edge advances the read pointer.
- in_ready = (count != DEPTH). It depends only on registered state and has no combinational path from out_ready.
- out_valid = (count != 0). Outputs present the head entry directly from storage; no combinational path from in_* to out_*.
- Latency: an entry pushed into an empty buffer appears on out_* the next cycle. There is no same-cycle bypass.
- Simultaneous push and pop:
  - Allowed whenever not full. count is unchanged and both pointers advance.
  - When full, in_ready is 0, so only the pop occurs.
  - When empty, only the push occurs.
- Pointers wrap modulo DEPTH. count saturates logically at DEPTH (never exceeds it) and never underflows.
- out_* holds stable while out_valid & !out_ready.
- Flags are computed at push time from the in_* values and stored. Let k = signed in_immediate:
  - zero = (in_result == 0); negative = in_result[WIDTH-1].
  - k == 0: carry = 0.
  - k > 0 (left shift by k, 1..15): carry = in_operand[WIDTH-k].
  - k < 0 (right shift by m = -k, 1..16): carry = in_operand[m-1]. For k = -16, carry = in_operand[15] and in_result is 0.
- in_result is not recomputed or checked against in_operand; the buffer trusts the shifter.
- Inputs sampled while in_ready = 0 are ignored. Upstream holds them until accepted.

Test Plan:
- Reset: hold rst_n=0 with traffic on in_* -> count=0, out_valid=0, in_ready=1. Assert rst_n low asynchronously while count=2 -> out_valid falls without a clock edge.
- Left-shift flags: in_operand=16'h8001, in_immediate=+1, in_result=16'h0002, in_dest=3 -> next cycle out_valid=1, out_dest=3, out_result=16'h0002, out_carry=1, out_zero=0, out_negative=0.
- Right-shift flags, including k=-16:
  - in_operand=16'h0003, in_immediate=-2, in_result=16'h0000 -> out_zero=1, out_carry=1.
  - in_operand=16'h8000, in_immediate=-16, in_result=0 -> out_carry=1.
- Backpressure/full: out_ready=0, push A then B -> count=2, in_ready=0. C held on in_* is not accepted. Raise out_ready -> A, then B, then C emerge in order with no loss or duplication.
- Simultaneous push/pop at count=1: in_valid=1, out_ready=1 for 8 cycles with incrementing in_result -> count stays 1, outputs are in strict order, pointers wrap cleanly.
- Zero-shift: in_immediate=0, in_operand=in_result=16'hFFFF -> out_carry=0, out_negative=1, out_zero=0.
